// File: rtl/axi4_lite_write_arbiter.sv
// Two-requester round-robin arbiter feeding one AXI4-Lite write slave port.
// Runs one complete AW+W+B transaction at a time and returns BRESP to the winner.
module axi4_lite_write_arbiter #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     axi_clk,
  input  logic                     resetn,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  output logic                     req0_ready,
  output logic                     req0_done,
  output logic [1:0]               req0_resp,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  output logic                     req1_ready,
  output logic                     req1_done,
  output logic [1:0]               req1_resp,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic                     write_addr_valid,
  input  logic                     write_addr_ready,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     write_data_valid,
  input  logic                     write_data_ready,
  input  logic [1:0]               write_resp,
  input  logic                     write_resp_valid,
  output logic                     write_resp_ready,
  output logic                     busy,
  output logic                     grant_id
);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t                   state, state_next;
  logic                     ptr, ptr_next;
  logic                     aw_done, aw_done_next;
  logic                     w_done, w_done_next;
  logic                     pick;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0]    data_next;
  logic                     awv_next, wv_next, br_next;
  logic                     r0_next, r1_next, d0_next, d1_next;
  logic [1:0]               resp0_next, resp1_next;
  logic                     gid_next, busy_next;
  logic                     aw_hs, w_hs, b_hs;

  // Valids are only ever high in their own state, so stray slave inputs are inert.
  assign aw_hs = write_addr_valid & write_addr_ready;
  assign w_hs  = write_data_valid & write_data_ready;
  assign b_hs  = write_resp_valid & write_resp_ready;

  always_ff @(posedge axi_clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    pick         = 1'b0;
    addr_next    = write_addr;
    data_next    = write_data;
    awv_next     = write_addr_valid;
    wv_next      = write_data_valid;
    br_next      = write_resp_ready;
    r0_next      = 1'b0;
    r1_next      = 1'b0;
    d0_next      = 1'b0;
    d1_next      = 1'b0;
    resp0_next   = req0_resp;
    resp1_next   = req1_resp;
    gid_next     = grant_id;
    case (state)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          // Pointer only matters under contention; a lone requester always wins.
          pick       = (req0_valid & req1_valid) ? ptr : req1_valid;
          gid_next   = pick;
          addr_next  = pick ? req1_addr : req0_addr;
          data_next  = pick ? req1_data : req0_data;
          r0_next    = ~pick;
          r1_next    = pick;
          awv_next   = 1'b1;
          wv_next    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (aw_hs) begin
          awv_next     = 1'b0;
          aw_done_next = 1'b1;
        end
        if (w_hs) begin
          wv_next     = 1'b0;
          w_done_next = 1'b1;
        end
        if (aw_done_next & w_done_next) begin
          br_next    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          br_next      = 1'b0;
          d0_next      = ~grant_id;
          d1_next      = grant_id;
          resp0_next   = grant_id ? req0_resp : write_resp;
          resp1_next   = grant_id ? write_resp : req1_resp;
          ptr_next     = ~grant_id;
          gid_next     = 1'b0;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge axi_clk or negedge resetn) begin
    if (!resetn) begin
      ptr              <= 1'b0;
      aw_done          <= 1'b0;
      w_done           <= 1'b0;
      write_addr       <= '0;
      write_data       <= '0;
      write_addr_valid <= 1'b0;
      write_data_valid <= 1'b0;
      write_resp_ready <= 1'b0;
      req0_ready       <= 1'b0;
      req1_ready       <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req0_resp        <= 2'b00;
      req1_resp        <= 2'b00;
      grant_id         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      ptr              <= ptr_next;
      aw_done          <= aw_done_next;
      w_done           <= w_done_next;
      write_addr       <= addr_next;
      write_data       <= data_next;
      write_addr_valid <= awv_next;
      write_data_valid <= wv_next;
      write_resp_ready <= br_next;
      req0_ready       <= r0_next;
      req1_ready       <= r1_next;
      req0_done        <= d0_next;
      req1_done        <= d1_next;
      req0_resp        <= resp0_next;
      req1_resp        <= resp1_next;
      grant_id         <= gid_next;
      busy             <= busy_next;
    end
  end

endmodule

// File: doc/axi4_lite_write_arbiter.md
Name: axi4_lite_write_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one AXI4-Lite write slave port (e.g. core store unit and debug/DMA port sharing the register-file write slave).
- Accepts a simple valid/ready write request from each requester and runs one complete AW+W+B transaction at a time on the shared port.
- Returns the B response to the winning requester.
- Round-robin fairness; only one transaction outstanding.

Parameters:
- ADDRESS_WIDTH, 2, width of write address on requester and AXI sides.
- DATA_WIDTH, 32, width of write data.

Ports:
- axi_clk  input  1  single clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDRESS_WIDTH  requester 0 write address
- req0_data  input  DATA_WIDTH  requester 0 write data
- req0_ready  output  1  one-cycle accept pulse to requester 0
- req0_done  output  1  one-cycle completion pulse to requester 0
- req0_resp  output  2  BRESP for requester 0, valid while req0_done=1
- req1_valid, req1_addr, req1_data, req1_ready, req1_done, req1_resp  same as requester 0, for requester 1
- write_addr  output  ADDRESS_WIDTH  AXI AWADDR
- write_addr_valid  output  1  AXI AWVALID
- write_addr_ready  input  1  AXI AWREADY
- write_data  output  DATA_WIDTH  AXI WDATA
- write_data_valid  output  1  AXI WVALID
- write_data_ready  input  1  AXI WREADY
- write_resp  input  2  AXI BRESP
- write_resp_valid  input  1  AXI BVALID
- write_resp_ready  output  1  AXI BREADY
- busy  output  1  high in any state other than IDLE
- grant_id  output  1  requester owning current transaction; 0 when IDLE

Behaviour:
- All outputs are registered.
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - All valid/ready/done outputs 0; write_addr, write_data, reqN_resp, grant_id all 0.
  - Priority pointer = requester 0.
- Reset mid-transaction: the outstanding AXI transaction is dropped silently. No done pulse is issued.
- States: IDLE, SEND, RESP.
- IDLE:
  - Sample req0_valid/req1_valid every cycle.
  - One valid: grant it.
  - Both valid: grant the requester indicated by the priority pointer.
  - On the grant edge:
    - Capture reqN_addr/reqN_data into write_addr/write_data.
    - Set grant_id.
    - Pulse reqN_ready for one cycle.
    - Set write_addr_valid=1 and write_data_valid=1.
    - Go to SEND.
  - Latency: request seen at edge k means ready pulse and AW/W valid are high in cycle k..k+1.
- SEND:
  - AW handshake = write_addr_valid & write_addr_ready at an edge; drop write_addr_valid on that edge and set aw_done.
  - W handshake = write_data_valid & write_data_ready at an edge; drop write_data_valid on that edge and set w_done.
  - AW and W complete independently, in either order or in the same cycle.
  - When both are done (flags or same-edge handshakes): go to RESP and set write_resp_ready=1 on that edge.
  - write_addr/write_data are held constant from grant until their handshake (AXI stability rule).
- RESP:
  - On write_resp_valid & write_resp_ready:
    - Clear write_resp_ready.
    - Pulse reqN_done for one cycle and drive reqN_resp=write_resp.
    - Set priority pointer to the other requester.
    - Clear aw_done/w_done and return to IDLE.
- Arbitration:
  - No new grant is made on the B-handshake edge. Re-arbitration happens in IDLE the following cycle, so there is a minimum of one idle cycle between transactions.
  - The pointer updates only on completion. The last-served requester gets lowest priority.
  - A single requester is served back-to-back regardless of the pointer.
- Ignored inputs:
  - reqN_valid is ignored outside IDLE; requests must be held until reqN_ready.
  - Deassertion before acceptance withdraws the request without error.
  - write_addr_ready/write_data_ready outside SEND and write_resp_valid outside RESP are ignored.
- Non-zero BRESP (e.g. 2'b10 SLVERR) is passed through unchanged; the transaction counts as complete.
- Non-granted requester's ready/done stay 0 throughout.

Test Plan:
- **Single request:** Reset, then req0 with addr=2'b00, data=32'hA5A5A5A5; slave keeps AWREADY=WREADY=1 and returns BRESP=2'b00 one cycle after BREADY.
  - req0_ready pulses once.
  - AWADDR=0 and WDATA=A5A5A5A5 are held until handshake.
  - req0_done=1 with req0_resp=00 for exactly one cycle.
  - busy returns 0.
- **Contention:** req0 and req1 asserted in the same cycle and held, with req1 addr=2'b01, data=32'h5A5A5A5A.
  - Requester 0 is served first (reset pointer), then requester 1 after one IDLE cycle.
  - Then with both still requesting, requester 0 is served next (strict alternation).
- **Split handshakes:** WREADY arrives 3 cycles before AWREADY, then the same case with AWREADY first.
  - Each valid drops on its own handshake edge.
  - BREADY rises only after both handshakes.
  - Exactly one done pulse.
- **Error response:** slave returns BRESP=2'b10 after 5 wait cycles.
  - req1_done pulses with req1_resp=2'b10.
  - The next transaction proceeds normally.
- **Reset mid-transaction:** resetn dropped while in SEND with AWVALID=1.
  - All outputs go to 0 immediately (asynchronously).
  - No done pulse.
  - After release, a new req0 completes normally with pointer=0.
- **Spurious inputs:** BVALID pulsed while in IDLE or SEND, and req1_valid toggled while req0's transaction is in flight.
  - No done pulse.
  - grant_id is unchanged.
  - req1 is accepted only after req0 completes.
